// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accel_pkg
// Purpose  : Shared definitions for the accelerator host controller: default
//            field widths and the controller state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package accel_pkg;

  localparam int c_BW_IF_ROWS     = 10;
  localparam int c_BW_IF_COLUMS   = 11;
  localparam int c_BW_IF_CHANNELS = 2;
  localparam int c_BW_W_ROWS      = 4;
  localparam int c_BW_W_COLUMS    = 4;
  localparam int c_BW_STRIDE      = 4;
  localparam int c_OFFMEM_ADDR_W  = 32;
  localparam int c_TIMEOUT_W      = 24;
  localparam int c_CYCLES_W       = 32;
  localparam int c_STATE_W        = 3;

  typedef enum logic [c_STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_CALC_R = 3'd1,
    S_CALC_C = 3'd2,
    S_START  = 3'd3,
    S_BUSY   = 3'd4,
    S_ACK    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/of_dim_calc.sv
`default_nettype none
// ============================================================================
// Module   : of_dim_calc
// Purpose  : Iterative output-dimension calculator. Computes
//            floor(diff / stride) + 1 by repeated subtraction, one
//            subtraction per enabled cycle.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            i_load        - load i_diff and restart the result at 1
//            i_en          - allow one subtraction this cycle
//            i_diff        - (input size - kernel size)
//            i_stride      - convolution stride
//            o_done        - remainder below stride, o_dim is final
//            o_dim         - computed output dimension
// Revision : 1.0 - initial release
// ============================================================================
module of_dim_calc #(
  parameter int DIM_WIDTH    = 10,
  parameter int STRIDE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_en,
  input  logic [DIM_WIDTH-1:0] i_diff,
  input  logic [STRIDE_WIDTH-1:0] i_stride,
  output logic                 o_done,
  output logic [DIM_WIDTH-1:0] o_dim
);

  logic [DIM_WIDTH-1:0] r_rem;
  logic [DIM_WIDTH-1:0] r_dim;
  logic [DIM_WIDTH-1:0] w_stride;

  assign w_stride = DIM_WIDTH'(i_stride);
  // A zero stride never reaches this block in normal flow; treating it as
  // done keeps the iteration from running away if it ever does.
  assign o_done   = (r_rem < w_stride) || (w_stride == '0);
  assign o_dim    = r_dim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_dim <= '0;
    end else if (i_load) begin
      r_rem <= i_diff;
      r_dim <= DIM_WIDTH'(1);
    end else if (i_en && !o_done) begin
      r_rem <= r_rem - w_stride;
      r_dim <= r_dim + DIM_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/accel_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : accel_host_ctrl
// Purpose  : Host-side job controller for a convolution accelerator. Accepts
//            a job descriptor, validates it, computes output feature-map
//            size, starts the accelerator, waits for completion with a
//            watchdog and reports done/error plus the busy cycle count.
// Ports    : ACCEL_HOST_Clk_50 / ACCEL_HOST_Reset - clock, async reset
//            ACCEL_HOST_JOB_*   - job descriptor handshake and fields
//            ACCEL_HOST_ACC_*   - registered configuration and start/finish
//                                 handshake towards the accelerator
//            ACCEL_HOST_DONE / _ERROR - one-cycle completion/reject pulses
//            ACCEL_HOST_CYCLES  - busy cycle count of the last job
// Revision : 1.0 - initial release
// ============================================================================
module accel_host_ctrl
  import accel_pkg::*;
#(
  parameter int BITWIDTH_IF_ROWS     = c_BW_IF_ROWS,
  parameter int BITWIDTH_IF_COLUMS   = c_BW_IF_COLUMS,
  parameter int BITWIDTH_IF_CHANNELS = c_BW_IF_CHANNELS,
  parameter int BITWIDTH_W_ROWS      = c_BW_W_ROWS,
  parameter int BITWIDTH_W_COLUMS    = c_BW_W_COLUMS,
  parameter int BITWIDTH_STRIDE      = c_BW_STRIDE,
  parameter int OFFMEM_ADDR_WIDTH    = c_OFFMEM_ADDR_W,
  parameter int TIMEOUT_WIDTH        = c_TIMEOUT_W
) (
  input  logic                            ACCEL_HOST_Clk_50,
  input  logic                            ACCEL_HOST_Reset,
  input  logic                            ACCEL_HOST_JOB_VALID,
  output logic                            ACCEL_HOST_JOB_READY,
  input  logic [OFFMEM_ADDR_WIDTH-1:0]    ACCEL_HOST_JOB_ADDR_OFFSET,
  input  logic [BITWIDTH_IF_ROWS-1:0]     ACCEL_HOST_JOB_IF_ROWS,
  input  logic [BITWIDTH_IF_COLUMS-1:0]   ACCEL_HOST_JOB_IF_COLUMS,
  input  logic [BITWIDTH_IF_CHANNELS-1:0] ACCEL_HOST_JOB_IF_CHANNELS,
  input  logic [BITWIDTH_W_ROWS-1:0]      ACCEL_HOST_JOB_W_ROWS,
  input  logic [BITWIDTH_W_COLUMS-1:0]    ACCEL_HOST_JOB_W_COLUMS,
  input  logic [BITWIDTH_STRIDE-1:0]      ACCEL_HOST_JOB_STRIDE,
  input  logic                            ACCEL_HOST_JOB_SAME_W,
  output logic [OFFMEM_ADDR_WIDTH-1:0]    ACCEL_HOST_ACC_ADDR_OFFSET,
  output logic [BITWIDTH_IF_ROWS-1:0]     ACCEL_HOST_ACC_IF_ROWS,
  output logic [BITWIDTH_IF_COLUMS-1:0]   ACCEL_HOST_ACC_IF_COLUMS,
  output logic [BITWIDTH_IF_CHANNELS-1:0] ACCEL_HOST_ACC_IF_CHANNELS,
  output logic [BITWIDTH_W_ROWS-1:0]      ACCEL_HOST_ACC_W_ROWS,
  output logic [BITWIDTH_W_COLUMS-1:0]    ACCEL_HOST_ACC_W_COLUMS,
  output logic [BITWIDTH_IF_CHANNELS-1:0] ACCEL_HOST_ACC_W_CHANNELS,
  output logic [BITWIDTH_IF_ROWS-1:0]     ACCEL_HOST_ACC_OF_ROWS,
  output logic [BITWIDTH_IF_COLUMS-1:0]   ACCEL_HOST_ACC_OF_COLUMS,
  output logic [BITWIDTH_STRIDE-1:0]      ACCEL_HOST_ACC_CONV_STRIDE,
  output logic                            ACCEL_HOST_ACC_SAME_W,
  output logic                            ACCEL_HOST_ACC_START,
  input  logic                            ACCEL_HOST_ACC_FINISHED,
  output logic                            ACCEL_HOST_ACC_FINISHED_OK,
  output logic                            ACCEL_HOST_DONE,
  output logic                            ACCEL_HOST_ERROR,
  output logic [c_CYCLES_W-1:0]           ACCEL_HOST_CYCLES
);

  state_t r_state;
  state_t w_next;

  logic                          w_accept;
  logic                          w_bad_job;
  logic                          w_row_done;
  logic                          w_col_done;
  logic [BITWIDTH_IF_ROWS-1:0]   w_row_dim;
  logic [BITWIDTH_IF_COLUMS-1:0] w_col_dim;
  logic [BITWIDTH_IF_ROWS-1:0]   w_row_diff;
  logic [BITWIDTH_IF_COLUMS-1:0] w_col_diff;
  logic [c_CYCLES_W-1:0]         r_cnt;
  logic [c_CYCLES_W-1:0]         w_cnt_inc;
  logic                          w_timeout;

  logic r_ready;
  logic r_start;
  logic r_fin_ok;
  logic r_done;
  logic r_error;
  logic [c_CYCLES_W-1:0] r_cycles;

  assign w_accept   = (r_state == S_IDLE) && ACCEL_HOST_JOB_VALID;
  assign w_bad_job  = (ACCEL_HOST_JOB_STRIDE == '0)
                   || (BITWIDTH_IF_ROWS'(ACCEL_HOST_JOB_W_ROWS) > ACCEL_HOST_JOB_IF_ROWS)
                   || (BITWIDTH_IF_COLUMS'(ACCEL_HOST_JOB_W_COLUMS) > ACCEL_HOST_JOB_IF_COLUMS);
  // Differences are only meaningful for accepted good jobs; bad jobs go to
  // ERR before either divider is enabled.
  assign w_row_diff = ACCEL_HOST_JOB_IF_ROWS - BITWIDTH_IF_ROWS'(ACCEL_HOST_JOB_W_ROWS);
  assign w_col_diff = ACCEL_HOST_JOB_IF_COLUMS - BITWIDTH_IF_COLUMS'(ACCEL_HOST_JOB_W_COLUMS);

  // Saturating increment; the watchdog looks at the count this BUSY cycle
  // would produce so that it fires after exactly 2^TIMEOUT_WIDTH-1 cycles.
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 32'd1;
  assign w_timeout  = &w_cnt_inc[TIMEOUT_WIDTH-1:0];

  // Both dividers load at accept; each is enabled only in its own state.
  of_dim_calc #(
    .DIM_WIDTH    (BITWIDTH_IF_ROWS),
    .STRIDE_WIDTH (BITWIDTH_STRIDE)
  ) u_row_calc (
    .clk      (ACCEL_HOST_Clk_50),
    .rst      (ACCEL_HOST_Reset),
    .i_load   (w_accept),
    .i_en     (r_state == S_CALC_R),
    .i_diff   (w_row_diff),
    .i_stride (ACCEL_HOST_ACC_CONV_STRIDE),
    .o_done   (w_row_done),
    .o_dim    (w_row_dim)
  );

  of_dim_calc #(
    .DIM_WIDTH    (BITWIDTH_IF_COLUMS),
    .STRIDE_WIDTH (BITWIDTH_STRIDE)
  ) u_col_calc (
    .clk      (ACCEL_HOST_Clk_50),
    .rst      (ACCEL_HOST_Reset),
    .i_load   (w_accept),
    .i_en     (r_state == S_CALC_C),
    .i_diff   (w_col_diff),
    .i_stride (ACCEL_HOST_ACC_CONV_STRIDE),
    .o_done   (w_col_done),
    .o_dim    (w_col_dim)
  );

  always_ff @(posedge ACCEL_HOST_Clk_50 or posedge ACCEL_HOST_Reset) begin
    if (ACCEL_HOST_Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (ACCEL_HOST_JOB_VALID) w_next = w_bad_job ? S_ERR : S_CALC_R;
      S_CALC_R: if (w_row_done) w_next = S_CALC_C;
      S_CALC_C: if (w_col_done) w_next = S_START;
      S_START:  w_next = S_BUSY;
      S_BUSY: begin
        if (ACCEL_HOST_ACC_FINISHED) w_next = S_ACK;
        else if (w_timeout)          w_next = S_ERR;
      end
      S_ACK:    if (!ACCEL_HOST_ACC_FINISHED) w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next-state decode so they line
  // up with the state and come straight out of flops.
  always_ff @(posedge ACCEL_HOST_Clk_50 or posedge ACCEL_HOST_Reset) begin
    if (ACCEL_HOST_Reset) begin
      r_ready  <= 1'b1;
      r_start  <= 1'b0;
      r_fin_ok <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_ready  <= (w_next == S_IDLE);
      r_start  <= (w_next == S_START);
      r_fin_ok <= (r_state == S_BUSY) && ACCEL_HOST_ACC_FINISHED;
      r_done   <= (r_state == S_BUSY) && ACCEL_HOST_ACC_FINISHED;
      r_error  <= (w_next == S_ERR);
    end
  end

  always_ff @(posedge ACCEL_HOST_Clk_50 or posedge ACCEL_HOST_Reset) begin
    if (ACCEL_HOST_Reset) begin
      r_cnt    <= '0;
      r_cycles <= '0;
    end else begin
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= w_cnt_inc;
        if (ACCEL_HOST_ACC_FINISHED) r_cycles <= w_cnt_inc;
      end
    end
  end

  always_ff @(posedge ACCEL_HOST_Clk_50 or posedge ACCEL_HOST_Reset) begin
    if (ACCEL_HOST_Reset) begin
      ACCEL_HOST_ACC_ADDR_OFFSET <= '0;
      ACCEL_HOST_ACC_IF_ROWS     <= '0;
      ACCEL_HOST_ACC_IF_COLUMS   <= '0;
      ACCEL_HOST_ACC_IF_CHANNELS <= '0;
      ACCEL_HOST_ACC_W_ROWS      <= '0;
      ACCEL_HOST_ACC_W_COLUMS    <= '0;
      ACCEL_HOST_ACC_W_CHANNELS  <= '0;
      ACCEL_HOST_ACC_OF_ROWS     <= '0;
      ACCEL_HOST_ACC_OF_COLUMS   <= '0;
      ACCEL_HOST_ACC_CONV_STRIDE <= '0;
      ACCEL_HOST_ACC_SAME_W      <= 1'b0;
    end else begin
      if (w_accept) begin
        ACCEL_HOST_ACC_ADDR_OFFSET <= ACCEL_HOST_JOB_ADDR_OFFSET;
        ACCEL_HOST_ACC_IF_ROWS     <= ACCEL_HOST_JOB_IF_ROWS;
        ACCEL_HOST_ACC_IF_COLUMS   <= ACCEL_HOST_JOB_IF_COLUMS;
        ACCEL_HOST_ACC_IF_CHANNELS <= ACCEL_HOST_JOB_IF_CHANNELS;
        ACCEL_HOST_ACC_W_ROWS      <= ACCEL_HOST_JOB_W_ROWS;
        ACCEL_HOST_ACC_W_COLUMS    <= ACCEL_HOST_JOB_W_COLUMS;
        ACCEL_HOST_ACC_W_CHANNELS  <= ACCEL_HOST_JOB_IF_CHANNELS;
        ACCEL_HOST_ACC_CONV_STRIDE <= ACCEL_HOST_JOB_STRIDE;
        ACCEL_HOST_ACC_SAME_W      <= ACCEL_HOST_JOB_SAME_W;
      end
      if ((r_state == S_CALC_R) && w_row_done) ACCEL_HOST_ACC_OF_ROWS   <= w_row_dim;
      if ((r_state == S_CALC_C) && w_col_done) ACCEL_HOST_ACC_OF_COLUMS <= w_col_dim;
    end
  end

  assign ACCEL_HOST_JOB_READY       = r_ready;
  assign ACCEL_HOST_ACC_START       = r_start;
  assign ACCEL_HOST_ACC_FINISHED_OK = r_fin_ok;
  assign ACCEL_HOST_DONE            = r_done;
  assign ACCEL_HOST_ERROR           = r_error;
  assign ACCEL_HOST_CYCLES          = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_accel_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_accel_host_ctrl
// Purpose  : Directed self-checking bench for accel_host_ctrl. A second
//            instance with a 4-bit watchdog exercises the timeout path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accel_host_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        valid2 = 1'b0;
  logic [31:0] addr = '0;
  logic [9:0]  ifr = '0;
  logic [10:0] ifc = '0;
  logic [1:0]  ifch = '0;
  logic [3:0]  wr = '0;
  logic [3:0]  wc = '0;
  logic [3:0]  stride = '0;
  logic        same = 1'b0;
  logic        fin = 1'b0;
  logic        fin2 = 1'b0;

  logic        ready, start, ok, done, error, acc_same;
  logic [31:0] acc_addr, cycles;
  logic [9:0]  acc_ifr, acc_ofr;
  logic [10:0] acc_ifc, acc_ofc;
  logic [1:0]  acc_ifch, acc_wch;
  logic [3:0]  acc_wr, acc_wc, acc_stride;

  logic        t_ready, t_start, t_ok, t_done, t_error, t_same;
  logic [31:0] t_addr, t_cycles;
  logic [9:0]  t_ifr, t_ofr;
  logic [10:0] t_ifc, t_ofc;
  logic [1:0]  t_ifch, t_wch;
  logic [3:0]  t_wr, t_wc, t_stride;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  accel_host_ctrl dut (
    .ACCEL_HOST_Clk_50          (clk),
    .ACCEL_HOST_Reset           (rst),
    .ACCEL_HOST_JOB_VALID       (valid),
    .ACCEL_HOST_JOB_READY       (ready),
    .ACCEL_HOST_JOB_ADDR_OFFSET (addr),
    .ACCEL_HOST_JOB_IF_ROWS     (ifr),
    .ACCEL_HOST_JOB_IF_COLUMS   (ifc),
    .ACCEL_HOST_JOB_IF_CHANNELS (ifch),
    .ACCEL_HOST_JOB_W_ROWS      (wr),
    .ACCEL_HOST_JOB_W_COLUMS    (wc),
    .ACCEL_HOST_JOB_STRIDE      (stride),
    .ACCEL_HOST_JOB_SAME_W      (same),
    .ACCEL_HOST_ACC_ADDR_OFFSET (acc_addr),
    .ACCEL_HOST_ACC_IF_ROWS     (acc_ifr),
    .ACCEL_HOST_ACC_IF_COLUMS   (acc_ifc),
    .ACCEL_HOST_ACC_IF_CHANNELS (acc_ifch),
    .ACCEL_HOST_ACC_W_ROWS      (acc_wr),
    .ACCEL_HOST_ACC_W_COLUMS    (acc_wc),
    .ACCEL_HOST_ACC_W_CHANNELS  (acc_wch),
    .ACCEL_HOST_ACC_OF_ROWS     (acc_ofr),
    .ACCEL_HOST_ACC_OF_COLUMS   (acc_ofc),
    .ACCEL_HOST_ACC_CONV_STRIDE (acc_stride),
    .ACCEL_HOST_ACC_SAME_W      (acc_same),
    .ACCEL_HOST_ACC_START       (start),
    .ACCEL_HOST_ACC_FINISHED    (fin),
    .ACCEL_HOST_ACC_FINISHED_OK (ok),
    .ACCEL_HOST_DONE            (done),
    .ACCEL_HOST_ERROR           (error),
    .ACCEL_HOST_CYCLES          (cycles)
  );

  accel_host_ctrl #(.TIMEOUT_WIDTH(4)) dut_to (
    .ACCEL_HOST_Clk_50          (clk),
    .ACCEL_HOST_Reset           (rst),
    .ACCEL_HOST_JOB_VALID       (valid2),
    .ACCEL_HOST_JOB_READY       (t_ready),
    .ACCEL_HOST_JOB_ADDR_OFFSET (addr),
    .ACCEL_HOST_JOB_IF_ROWS     (ifr),
    .ACCEL_HOST_JOB_IF_COLUMS   (ifc),
    .ACCEL_HOST_JOB_IF_CHANNELS (ifch),
    .ACCEL_HOST_JOB_W_ROWS      (wr),
    .ACCEL_HOST_JOB_W_COLUMS    (wc),
    .ACCEL_HOST_JOB_STRIDE      (stride),
    .ACCEL_HOST_JOB_SAME_W      (same),
    .ACCEL_HOST_ACC_ADDR_OFFSET (t_addr),
    .ACCEL_HOST_ACC_IF_ROWS     (t_ifr),
    .ACCEL_HOST_ACC_IF_COLUMS   (t_ifc),
    .ACCEL_HOST_ACC_IF_CHANNELS (t_ifch),
    .ACCEL_HOST_ACC_W_ROWS      (t_wr),
    .ACCEL_HOST_ACC_W_COLUMS    (t_wc),
    .ACCEL_HOST_ACC_W_CHANNELS  (t_wch),
    .ACCEL_HOST_ACC_OF_ROWS     (t_ofr),
    .ACCEL_HOST_ACC_OF_COLUMS   (t_ofc),
    .ACCEL_HOST_ACC_CONV_STRIDE (t_stride),
    .ACCEL_HOST_ACC_SAME_W      (t_same),
    .ACCEL_HOST_ACC_START       (t_start),
    .ACCEL_HOST_ACC_FINISHED    (fin2),
    .ACCEL_HOST_ACC_FINISHED_OK (t_ok),
    .ACCEL_HOST_DONE            (t_done),
    .ACCEL_HOST_ERROR           (t_error),
    .ACCEL_HOST_CYCLES          (t_cycles)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic set_job(input logic [31:0] a, input logic [9:0] r, input logic [10:0] c,
                         input logic [1:0] ch, input logic [3:0] kr, input logic [3:0] kc,
                         input logic [3:0] s, input logic sw);
    addr = a; ifr = r; ifc = c; ifch = ch; wr = kr; wc = kc; stride = s; same = sw;
  endtask

  // Presents the job for one cycle; returns at the negedge of the cycle
  // after acceptance (cycle 1).
  task automatic submit();
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Latency in cycles from acceptance to the START pulse, bounded.
  task automatic wait_start(output int lat);
    lat = 1;
    while (start !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    n_assert++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_in_reset: got %0d expected 1", ready); end
    n_assert++; if (start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %0d expected 0", start); end
    rst = 1'b0;
    @(negedge clk);
    n_assert++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %0d expected 1", ready); end
    n_assert++; if ({ok, done, error} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %b expected 000", {ok, done, error}); end
    n_assert++; if (acc_ofr !== 10'd0) begin n_fail++; $display("FAIL rst_of_rows: got %0d expected 0", acc_ofr); end
    n_assert++; if (cycles !== 32'd0) begin n_fail++; $display("FAIL rst_cycles: got %0d expected 0", cycles); end
  endtask

  task automatic test_basic();
    int lat;
    int starts;
    int dones;
    set_job(32'd9, 10'd8, 11'd8, 2'd3, 4'd4, 4'd5, 4'd1, 1'b1);
    submit();
    wait_start(lat);
    n_assert++; if (lat != 10) begin n_fail++; $display("FAIL basic_latency: got %0d expected 10", lat); end
    n_assert++; if (acc_ofr !== 10'd5) begin n_fail++; $display("FAIL basic_of_rows: got %0d expected 5", acc_ofr); end
    n_assert++; if (acc_ofc !== 11'd4) begin n_fail++; $display("FAIL basic_of_cols: got %0d expected 4", acc_ofc); end
    n_assert++; if (acc_wch !== 2'd3) begin n_fail++; $display("FAIL basic_w_channels: got %0d expected 3", acc_wch); end
    n_assert++; if (acc_addr !== 32'd9) begin n_fail++; $display("FAIL basic_addr: got %0d expected 9", acc_addr); end
    n_assert++; if (acc_same !== 1'b1) begin n_fail++; $display("FAIL basic_same_w: got %0d expected 1", acc_same); end
    n_assert++; if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_busy: got %0d expected 0", ready); end
    starts = 0;
    dones  = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (start === 1'b1) starts++;
      if (done === 1'b1 || ok === 1'b1) dones++;
      // A descriptor offered while busy must be ignored.
      if (i == 50) begin valid = 1'b1; addr = 32'd77; end
      if (i == 51) valid = 1'b0;
    end
    fin = 1'b1;
    @(negedge clk);
    n_assert++; if (starts != 0) begin n_fail++; $display("FAIL basic_extra_start: got %0d expected 0", starts); end
    n_assert++; if (dones != 0) begin n_fail++; $display("FAIL basic_early_done: got %0d expected 0", dones); end
    n_assert++; if ({ok, done} !== 2'b11) begin n_fail++; $display("FAIL basic_ack: got %b expected 11", {ok, done}); end
    n_assert++; if (cycles !== 32'd100) begin n_fail++; $display("FAIL basic_cycles: got %0d expected 100", cycles); end
    n_assert++; if (acc_addr !== 32'd9) begin n_fail++; $display("FAIL basic_addr_held: got %0d expected 9", acc_addr); end
    fin = 1'b0;
    @(negedge clk);
    n_assert++; if (ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_end: got %0d expected 1", ready); end
    n_assert++; if ({ok, done} !== 2'b00) begin n_fail++; $display("FAIL basic_ack_single: got %b expected 00", {ok, done}); end
  endtask

  task automatic test_stride2();
    int lat;
    set_job(32'd0, 10'd9, 11'd9, 2'd1, 4'd3, 4'd3, 4'd2, 1'b0);
    submit();
    wait_start(lat);
    n_assert++; if (lat != 9) begin n_fail++; $display("FAIL s2_latency: got %0d expected 9", lat); end
    n_assert++; if (acc_ofr !== 10'd4) begin n_fail++; $display("FAIL s2_of_rows: got %0d expected 4", acc_ofr); end
    n_assert++; if (acc_ofc !== 11'd4) begin n_fail++; $display("FAIL s2_of_cols: got %0d expected 4", acc_ofc); end
    @(negedge clk);
    fin = 1'b1;
    @(negedge clk);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL s2_ack: got %0d expected 1", ok); end
    n_assert++; if (cycles !== 32'd1) begin n_fail++; $display("FAIL s2_cycles: got %0d expected 1", cycles); end
    fin = 1'b0;
    @(negedge clk);
    n_assert++; if (ready !== 1'b1) begin n_fail++; $display("FAIL s2_ready_end: got %0d expected 1", ready); end
  endtask

  task automatic test_errors();
    set_job(32'd5, 10'd8, 11'd8, 2'd1, 4'd4, 4'd4, 4'd0, 1'b0);
    submit();
    n_assert++; if ({error, start, ready} !== 3'b100) begin n_fail++; $display("FAIL err_stride0: got %b expected 100", {error, start, ready}); end
    n_assert++; if (acc_ofr !== 10'd4) begin n_fail++; $display("FAIL err_of_rows_kept: got %0d expected 4", acc_ofr); end
    @(negedge clk);
    n_assert++; if ({error, start, ready} !== 3'b001) begin n_fail++; $display("FAIL err_stride0_after: got %b expected 001", {error, start, ready}); end
    set_job(32'd6, 10'd8, 11'd8, 2'd1, 4'd9, 4'd4, 4'd1, 1'b0);
    submit();
    n_assert++; if ({error, start, ready} !== 3'b100) begin n_fail++; $display("FAIL err_wrows: got %b expected 100", {error, start, ready}); end
    @(negedge clk);
    n_assert++; if ({error, start, ready} !== 3'b001) begin n_fail++; $display("FAIL err_wrows_after: got %b expected 001", {error, start, ready}); end
  endtask

  task automatic test_boundary();
    int lat;
    set_job(32'd1, 10'd8, 11'd8, 2'd2, 4'd8, 4'd8, 4'd1, 1'b0);
    submit();
    wait_start(lat);
    n_assert++; if (lat != 3) begin n_fail++; $display("FAIL bnd_latency: got %0d expected 3", lat); end
    n_assert++; if ({acc_ofr, acc_ofc} !== {10'd1, 11'd1}) begin n_fail++; $display("FAIL bnd_of: got %0d x %0d expected 1 x 1", acc_ofr, acc_ofc); end
    @(negedge clk);
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    @(negedge clk);
    n_assert++; if (ready !== 1'b1) begin n_fail++; $display("FAIL bnd_ready_end: got %0d expected 1", ready); end
  endtask

  task automatic test_finished_hold();
    int lat;
    int oks;
    set_job(32'd2, 10'd6, 11'd6, 2'd1, 4'd6, 4'd6, 4'd1, 1'b0);
    submit();
    wait_start(lat);
    @(negedge clk);
    fin = 1'b1;
    oks = 0;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      if (ok === 1'b1) oks++;
    end
    n_assert++; if (ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ack: got ready %0d expected 0", ready); end
    fin = 1'b0;
    @(negedge clk);
    n_assert++; if (oks != 1) begin n_fail++; $display("FAIL hold_ok_count: got %0d expected 1", oks); end
    n_assert++; if (ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_end: got %0d expected 1", ready); end
    n_assert++; if (cycles !== 32'd1) begin n_fail++; $display("FAIL hold_cycles: got %0d expected 1", cycles); end
  endtask

  task automatic test_idle_finished();
    int hits;
    hits = 0;
    fin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ok === 1'b1 || done === 1'b1 || ready !== 1'b1) hits++;
    end
    fin = 1'b0;
    n_assert++; if (hits != 0) begin n_fail++; $display("FAIL idle_finished: got %0d reactions expected 0", hits); end
  endtask

  task automatic test_reset_busy();
    int lat;
    set_job(32'd3, 10'd8, 11'd8, 2'd3, 4'd4, 4'd5, 4'd1, 1'b0);
    submit();
    wait_start(lat);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_assert++; if ({start, ok, done, error} !== 4'b0000) begin n_fail++; $display("FAIL rb_pulses: got %b expected 0000", {start, ok, done, error}); end
    n_assert++; if ({acc_ofr, acc_addr, cycles} !== '0) begin n_fail++; $display("FAIL rb_regs: got of %0d addr %0d cyc %0d expected 0", acc_ofr, acc_addr, cycles); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_assert++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rb_ready: got %0d expected 1", ready); end
    submit();
    wait_start(lat);
    n_assert++; if (lat != 10) begin n_fail++; $display("FAIL rb_latency: got %0d expected 10", lat); end
    n_assert++; if (acc_ofr !== 10'd5) begin n_fail++; $display("FAIL rb_of_rows: got %0d expected 5", acc_ofr); end
    @(negedge clk);
    fin = 1'b1;
    @(negedge clk);
    n_assert++; if ({ok, done} !== 2'b11) begin n_fail++; $display("FAIL rb_ack: got %b expected 11", {ok, done}); end
    fin = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    int errs;
    set_job(32'd4, 10'd4, 11'd4, 2'd1, 4'd4, 4'd4, 4'd1, 1'b0);
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    lat = 1;
    while (t_start !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    n_assert++; if (lat != 3) begin n_fail++; $display("FAIL to_latency: got %0d expected 3", lat); end
    errs = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (t_error === 1'b1) errs++;
    end
    n_assert++; if (errs != 0) begin n_fail++; $display("FAIL to_early_error: got %0d expected 0", errs); end
    @(negedge clk);
    n_assert++; if ({t_error, t_done} !== 2'b10) begin n_fail++; $display("FAIL to_error: got %b expected 10", {t_error, t_done}); end
    @(negedge clk);
    n_assert++; if ({t_error, t_ready} !== 2'b01) begin n_fail++; $display("FAIL to_ready: got %b expected 01", {t_error, t_ready}); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_stride2();
    test_errors();
    test_boundary();
    test_finished_hold();
    test_idle_finished();
    test_reset_busy();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
